// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word plus PC+step into the IF/ID boundary.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  input  logic [31:0] IM_Data,
  output logic [31:0] IM_Addr,
  output logic [31:0] PC_Out,
  output logic [31:0] IM_Out,
  output logic [31:0] PCI_Out,
  output logic        Valid_Out,
  output logic [31:0] FetchCount,
  output logic        AlignErr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pci_q, pci_d;
  logic        vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;
  logic        aerr_q, aerr_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + PC_STEP;

  always_comb begin
    // Redirect wins over Stall for the PC; the target is forced word-aligned.
    pc_d = pc_inc;
    if (Redirect)   pc_d = {RedirectAddr[31:2], 2'b00};
    else if (Stall) pc_d = pc_q;

    ir_d  = ir_q;
    pci_d = pci_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (Flush) begin
      ir_d  = 32'h0;
      pci_d = 32'h0;
      vld_d = 1'b0;
    end else if (!Stall) begin
      ir_d  = IM_Data;
      pci_d = pc_inc;
      vld_d = 1'b1;
      cnt_d = cnt_q + 32'd1;
    end

    aerr_d = aerr_q | (Redirect & (|RedirectAddr[1:0]));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q   <= RESET_PC;
      ir_q   <= 32'h0;
      pci_q  <= 32'h0;
      vld_q  <= 1'b0;
      cnt_q  <= 32'h0;
      aerr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      pci_q  <= pci_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      aerr_q <= aerr_d;
    end
  end

  assign IM_Addr    = pc_q;
  assign PC_Out     = pc_q;
  assign IM_Out     = ir_q;
  assign PCI_Out    = pci_q;
  assign Valid_Out  = vld_q;
  assign FetchCount = cnt_q;
  assign AlignErr   = aerr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against
// a cycle-level reference of the fetch rules.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0, Flush = 1'b0, Redirect = 1'b0;
  logic [31:0] RedirectAddr = 32'h0;
  logic [31:0] IM_Data, IM_Addr, PC_Out, IM_Out, PCI_Out, FetchCount;
  logic        Valid_Out, AlignErr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign IM_Data = memf(IM_Addr);

  if_fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .IM_Data(IM_Data), .IM_Addr(IM_Addr),
    .PC_Out(PC_Out), .IM_Out(IM_Out), .PCI_Out(PCI_Out), .Valid_Out(Valid_Out),
    .FetchCount(FetchCount), .AlignErr(AlignErr)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Stall = 0; Flush = 0; Redirect = 0; RedirectAddr = 0;
    Rst = 1;
    #2;
    Rst = 0;
  endtask

  task automatic test_reset();
    Rst = 1;
    #1;
    n_cmp++; if (PC_Out !== 32'h0 || IM_Addr !== 32'h0) begin n_err++;
      $display("FAIL reset_pc: got %h/%h want 0", PC_Out, IM_Addr); end
    n_cmp++; if (IM_Out !== 0 || PCI_Out !== 0 || Valid_Out !== 0) begin n_err++;
      $display("FAIL reset_ifid: got %h %h %b want 0 0 0", IM_Out, PCI_Out, Valid_Out); end
    n_cmp++; if (FetchCount !== 0 || AlignErr !== 0) begin n_err++;
      $display("FAIL reset_cnt: got %0d %b want 0 0", FetchCount, AlignErr); end
  endtask

  task automatic test_seq();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (IM_Out !== 32'hA000_0000 + k || PCI_Out !== 4 * (k + 1) || Valid_Out !== 1'b1) begin
        n_err++;
        $display("FAIL seq_%0d: got %h %h %b want %h %h 1", k, IM_Out, PCI_Out, Valid_Out,
                 32'hA000_0000 + k, 4 * (k + 1));
      end
    end
    n_cmp++; if (FetchCount !== 4 || PC_Out !== 16) begin n_err++;
      $display("FAIL seq_cnt: got cnt %0d pc %h want 4 10", FetchCount, PC_Out); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (PC_Out !== 8 || IM_Out !== 32'hA000_0001 || PCI_Out !== 8 || FetchCount !== 2) begin
        n_err++;
        $display("FAIL stall_%0d: got pc %h ir %h pci %h cnt %0d want 8 a0000001 8 2",
                 k, PC_Out, IM_Out, PCI_Out, FetchCount);
      end
    end
    Stall = 0;
    tick();
    n_cmp++; if (IM_Out !== 32'hA000_0002 || PCI_Out !== 12 || FetchCount !== 3) begin n_err++;
      $display("FAIL stall_release: got %h %h %0d want a0000002 c 3", IM_Out, PCI_Out, FetchCount); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    tick(); tick(); tick();
    Redirect = 1; Flush = 1; RedirectAddr = 32'h40;
    tick();
    Redirect = 0; Flush = 0;
    n_cmp++; if (PC_Out !== 32'h40 || Valid_Out !== 0 || IM_Out !== 0 || PCI_Out !== 0) begin n_err++;
      $display("FAIL rflush_bubble: got pc %h v %b ir %h pci %h want 40 0 0 0",
               PC_Out, Valid_Out, IM_Out, PCI_Out); end
    tick();
    n_cmp++; if (IM_Out !== 32'hA000_0010 || PCI_Out !== 32'h44 || Valid_Out !== 1) begin n_err++;
      $display("FAIL rflush_target: got %h %h %b want a0000010 44 1", IM_Out, PCI_Out, Valid_Out); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    tick(); tick(); tick();
    Redirect = 1; RedirectAddr = 32'h40;
    tick();
    Redirect = 0;
    n_cmp++; if (IM_Out !== 32'hA000_0003 || PCI_Out !== 16 || PC_Out !== 32'h40 || FetchCount !== 4) begin
      n_err++;
      $display("FAIL delay_slot: got ir %h pci %h pc %h cnt %0d want a0000003 10 40 4",
               IM_Out, PCI_Out, PC_Out, FetchCount);
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick(); tick();
    Stall = 1; Flush = 1; Redirect = 1; RedirectAddr = 32'h80;
    tick();
    Stall = 0; Flush = 0; Redirect = 0;
    n_cmp++; if (Valid_Out !== 0 || PC_Out !== 32'h80 || FetchCount !== 2) begin n_err++;
      $display("FAIL priority: got v %b pc %h cnt %0d want 0 80 2", Valid_Out, PC_Out, FetchCount); end
  endtask

  task automatic test_wrap();
    do_reset();
    Redirect = 1; RedirectAddr = 32'hFFFF_FFFC;
    tick();
    Redirect = 0;
    tick();
    n_cmp++; if (PC_Out !== 0 || PCI_Out !== 0 || IM_Out !== memf(32'hFFFF_FFFC)) begin n_err++;
      $display("FAIL pc_wrap: got pc %h pci %h ir %h want 0 0 %h", PC_Out, PCI_Out, IM_Out,
               memf(32'hFFFF_FFFC)); end
  endtask

  task automatic test_misalign_async();
    do_reset();
    tick();
    Redirect = 1; RedirectAddr = 32'h43;
    tick();
    Redirect = 0;
    n_cmp++; if (PC_Out !== 32'h40 || AlignErr !== 1) begin n_err++;
      $display("FAIL misalign: got pc %h aerr %b want 40 1", PC_Out, AlignErr); end
    tick();
    n_cmp++; if (AlignErr !== 1) begin n_err++;
      $display("FAIL misalign_sticky: got %b want 1", AlignErr); end
    Stall = 1; Redirect = 1; RedirectAddr = 32'h100;
    #2;
    Rst = 1;
    #1;
    n_cmp++; if (AlignErr !== 0 || PC_Out !== 0 || IM_Out !== 0 || PCI_Out !== 0 ||
                 Valid_Out !== 0 || FetchCount !== 0) begin n_err++;
      $display("FAIL async_reset: got aerr %b pc %h ir %h pci %h v %b cnt %0d want all 0",
               AlignErr, PC_Out, IM_Out, PCI_Out, Valid_Out, FetchCount); end
    Stall = 0; Redirect = 0;
    #1 Rst = 0;
  endtask

  task automatic test_random();
    logic [31:0] pc, ir, pci, cnt;
    logic v, ae;
    do_reset();
    pc = 0; ir = 0; pci = 0; v = 0; cnt = 0; ae = 0;
    for (int c = 0; c < 400; c++) begin
      Stall    = ($urandom_range(0, 99) < 30);
      Flush    = ($urandom_range(0, 99) < 15);
      Redirect = ($urandom_range(0, 99) < 15);
      RedirectAddr = ($urandom_range(0, 3) == 0) ? $urandom : {22'h0, $urandom_range(0, 1023)};
      // Outcome of this edge, following the fetch rules directly.
      if (Flush) begin
        ir = 0; pci = 0; v = 0;
      end else if (!Stall) begin
        ir = memf(pc); pci = pc + 4; v = 1; cnt = cnt + 1;
      end
      if (Redirect && RedirectAddr[1:0] != 0) ae = 1;
      if (Redirect) pc = RedirectAddr & 32'hFFFF_FFFC;
      else if (!Stall) pc = pc + 4;
      tick();
      n_cmp++; if (PC_Out !== pc || IM_Addr !== pc || IM_Out !== ir || PCI_Out !== pci ||
                   Valid_Out !== v || FetchCount !== cnt || AlignErr !== ae) begin
        n_err++;
        $display("FAIL rand_%0d: got pc %h ir %h pci %h v %b cnt %0d ae %b want %h %h %h %b %0d %b",
                 c, PC_Out, IM_Out, PCI_Out, Valid_Out, FetchCount, AlignErr,
                 pc, ir, pci, v, cnt, ae);
      end
    end
    Stall = 0; Flush = 0; Redirect = 0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect_flush();
    test_delay_slot();
    test_priority();
    test_wrap();
    test_misalign_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
